// File: rtl/gate_actuator.sv
// Barrier gate actuator: opens on an entry/exit request, waits for a car,
// closes again and reports pass or timeout with a single-cycle pulse.
module gate_actuator #(
  parameter int  T_MOVE = 4,
  parameter int  T_WAIT = 8,
  localparam int PW     = $clog2(T_MOVE + 1),
  localparam int TW     = $clog2(T_WAIT + 1)
) (
  input  logic          clk_2,
  input  logic          reset,
  input  logic          req_in,
  input  logic          req_out,
  input  logic          car_present,
  output logic          motor_up,
  output logic          motor_down,
  output logic          barrier_open,
  output logic          busy,
  output logic          dir,
  output logic          ack_in,
  output logic          ack_out,
  output logic          abort,
  output logic [PW-1:0] pos
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_OPENING  = 3'd1;
  localparam logic [2:0] S_WAIT_CAR = 3'd2;
  localparam logic [2:0] S_PASSING  = 3'd3;
  localparam logic [2:0] S_CLOSING  = 3'd4;

  localparam logic [PW-1:0] POS_MAX  = PW'(T_MOVE);
  localparam logic [PW-1:0] POS_ONE  = PW'(1);
  localparam logic [TW-1:0] TMR_LAST = TW'(T_WAIT - 1);

  logic [2:0]    r_state, w_state_nxt;
  logic [PW-1:0] r_pos, w_pos_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          r_dir, w_dir_nxt;
  logic          r_aborted, w_aborted_nxt;
  logic          r_ack_in, w_ack_in_nxt;
  logic          r_ack_out, w_ack_out_nxt;
  logic          r_abort, w_abort_nxt;
  logic          r_motor_up, r_motor_down, r_barrier_open, r_busy;
  logic          w_pulse_busy;

  // A request held across the end of a cycle must not be re-accepted while its pulse is still visible.
  assign w_pulse_busy = r_ack_in | r_ack_out | r_abort;

  // Next-state, position, timer and completion-pulse decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_pos_nxt     = r_pos;
    w_timer_nxt   = r_timer;
    w_dir_nxt     = r_dir;
    w_aborted_nxt = r_aborted;
    w_ack_in_nxt  = 1'b0;
    w_ack_out_nxt = 1'b0;
    w_abort_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pulse_busy) begin
          w_state_nxt = S_IDLE;
        end else if (req_in) begin
          w_state_nxt = S_OPENING;
          w_dir_nxt   = 1'b0;
        end else if (req_out) begin
          w_state_nxt = S_OPENING;
          w_dir_nxt   = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_OPENING: begin
        if (r_pos >= (POS_MAX - POS_ONE)) begin
          w_pos_nxt   = POS_MAX;
          w_state_nxt = S_WAIT_CAR;
          w_timer_nxt = '0;
        end else begin
          w_pos_nxt = r_pos + POS_ONE;
        end
      end
      S_WAIT_CAR: begin
        if (car_present) begin
          w_state_nxt = S_PASSING;
        end else if (r_timer == TMR_LAST) begin
          w_state_nxt   = S_CLOSING;
          w_aborted_nxt = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      S_PASSING: begin
        if (!car_present) begin
          w_state_nxt   = S_CLOSING;
          w_aborted_nxt = 1'b0;
        end else begin
          w_state_nxt = S_PASSING;
        end
      end
      S_CLOSING: begin
        // Safety reversal keeps the current position; the car now gets a fresh wait.
        if (car_present) begin
          w_state_nxt   = S_OPENING;
          w_aborted_nxt = 1'b0;
        end else if (r_pos <= POS_ONE) begin
          w_pos_nxt   = '0;
          w_state_nxt = S_IDLE;
          if (r_aborted) begin
            w_abort_nxt = 1'b1;
          end else if (r_dir) begin
            w_ack_out_nxt = 1'b1;
          end else begin
            w_ack_in_nxt = 1'b1;
          end
        end else begin
          w_pos_nxt = r_pos - POS_ONE;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_pos_nxt     = '0;
        w_timer_nxt   = '0;
        w_aborted_nxt = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset wins over everything and emits no pulse.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_pos          <= '0;
      r_timer        <= '0;
      r_dir          <= 1'b0;
      r_aborted      <= 1'b0;
      r_ack_in       <= 1'b0;
      r_ack_out      <= 1'b0;
      r_abort        <= 1'b0;
      r_motor_up     <= 1'b0;
      r_motor_down   <= 1'b0;
      r_barrier_open <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_pos          <= w_pos_nxt;
      r_timer        <= w_timer_nxt;
      r_dir          <= w_dir_nxt;
      r_aborted      <= w_aborted_nxt;
      r_ack_in       <= w_ack_in_nxt;
      r_ack_out      <= w_ack_out_nxt;
      r_abort        <= w_abort_nxt;
      r_motor_up     <= (w_state_nxt == S_OPENING);
      r_motor_down   <= (w_state_nxt == S_CLOSING);
      r_barrier_open <= (w_pos_nxt == POS_MAX);
      r_busy         <= (w_state_nxt != S_IDLE);
    end
  end

  assign motor_up     = r_motor_up;
  assign motor_down   = r_motor_down;
  assign barrier_open = r_barrier_open;
  assign busy         = r_busy;
  assign dir          = r_dir;
  assign ack_in       = r_ack_in;
  assign ack_out      = r_ack_out;
  assign abort        = r_abort;
  assign pos          = r_pos;

endmodule

// File: tb/tb_gate_actuator.sv
// Testbench for gate_actuator: directed scenarios plus randomized traffic,
// all checked against a phase-level reference model of the barrier.
module tb_gate_actuator;
  localparam int T_MOVE = 4;
  localparam int T_WAIT = 8;
  localparam int PW     = $clog2(T_MOVE + 1);

  typedef enum int {P_IDLE, P_UP, P_WAIT, P_CAR, P_DOWN} phase_t;

  logic          clk_2 = 1'b0;
  logic          reset = 1'b1;
  logic          req_in = 1'b0, req_out = 1'b0, car_present = 1'b0;
  logic          motor_up, motor_down, barrier_open, busy, dir;
  logic          ack_in, ack_out, abort;
  logic [PW-1:0] pos;

  int n_vec = 0, n_bad = 0;
  int n_up, n_down, n_ai, n_ao, n_ab;
  phase_t m_phase = P_IDLE;
  int m_pos = 0, m_timer = 0, m_dir = 0, m_abt = 0, m_ai = 0, m_ao = 0, m_ab = 0;

  always #5 clk_2 = ~clk_2;

  gate_actuator #(.T_MOVE(T_MOVE), .T_WAIT(T_WAIT)) dut (
    .clk_2(clk_2), .reset(reset), .req_in(req_in), .req_out(req_out),
    .car_present(car_present), .motor_up(motor_up), .motor_down(motor_down),
    .barrier_open(barrier_open), .busy(busy), .dir(dir), .ack_in(ack_in),
    .ack_out(ack_out), .abort(abort), .pos(pos)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the barrier as a travel phase plus integer position and wait count.
  task automatic model_step(input logic rst, input logic ri, input logic ro, input logic car);
    int was_pulse;
    if (rst) begin
      m_phase = P_IDLE; m_pos = 0; m_timer = 0; m_dir = 0; m_abt = 0;
      m_ai = 0; m_ao = 0; m_ab = 0;
    end else begin
      was_pulse = m_ai + m_ao + m_ab;
      m_ai = 0; m_ao = 0; m_ab = 0;
      case (m_phase)
        P_IDLE: if (was_pulse == 0 && (ri || ro)) begin
          m_phase = P_UP;
          m_dir = ri ? 0 : 1;
        end
        P_UP: begin
          m_pos = (m_pos + 1 > T_MOVE) ? T_MOVE : m_pos + 1;
          if (m_pos == T_MOVE) begin m_phase = P_WAIT; m_timer = 0; end
        end
        P_WAIT: begin
          if (car) m_phase = P_CAR;
          else if (m_timer == T_WAIT - 1) begin m_phase = P_DOWN; m_abt = 1; end
          else m_timer++;
        end
        P_CAR: if (!car) begin m_phase = P_DOWN; m_abt = 0; end
        P_DOWN: begin
          if (car) begin
            m_phase = P_UP; m_abt = 0;
          end else begin
            m_pos = (m_pos > 0) ? m_pos - 1 : 0;
            if (m_pos == 0) begin
              m_phase = P_IDLE;
              if (m_abt != 0) m_ab = 1;
              else if (m_dir != 0) m_ao = 1;
              else m_ai = 1;
            end
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  task automatic compare_all();
    chk("motor_up", motor_up, int'(m_phase == P_UP));
    chk("motor_down", motor_down, int'(m_phase == P_DOWN));
    chk("pos", pos, m_pos);
    chk("barrier_open", barrier_open, int'(m_pos == T_MOVE));
    chk("busy", busy, int'(m_phase != P_IDLE));
    chk("dir", dir, m_dir);
    chk("ack_in", ack_in, m_ai);
    chk("ack_out", ack_out, m_ao);
    chk("abort", abort, m_ab);
    chk("inv_motors", int'(motor_up & motor_down), 0);
    chk("inv_pos", int'(pos <= T_MOVE), 1);
    chk("inv_pulse", int'((int'(ack_in) + int'(ack_out) + int'(abort)) <= 1), 1);
    n_up += int'(motor_up); n_down += int'(motor_down);
    n_ai += int'(ack_in); n_ao += int'(ack_out); n_ab += int'(abort);
  endtask

  task automatic cycle(input logic rst, input logic ri, input logic ro, input logic car);
    @(negedge clk_2);
    reset = rst; req_in = ri; req_out = ro; car_present = car;
    @(posedge clk_2);
    model_step(rst, ri, ro, car);
    #1;
    compare_all();
  endtask

  task automatic clr();
    n_up = 0; n_down = 0; n_ai = 0; n_ao = 0; n_ab = 0;
  endtask

  task automatic run_until(input phase_t tgt, input int tgt_pos, input logic ri, input logic ro,
                           input logic car, input int maxc, input string tag);
    int k;
    k = 0;
    while (!(m_phase == tgt && (tgt_pos < 0 || m_pos == tgt_pos)) && k < maxc) begin
      cycle(1'b0, ri, ro, car);
      k++;
    end
    chk({tag, "_bound"}, int'(k < maxc), 1);
  endtask

  initial begin
    logic rr_in, rr_out, rcar, rrst;
    clr();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_pos", pos, 0);
    chk("rst_busy", busy, 0);

    // Entry pass
    clr();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("entry_open", barrier_open, 1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (8) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("entry_up_cycles", n_up, 4);
    chk("entry_down_cycles", n_down, 4);
    chk("entry_ack_in", n_ai, 1);
    chk("entry_other_pulses", n_ao + n_ab, 0);

    // Exit timeout
    clr();
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (18) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_abort", n_ab, 1);
    chk("to_ack_out", n_ao, 0);
    chk("to_dir", dir, 1);
    chk("to_busy", busy, 0);

    // Simultaneous requests: entry wins, exit follows after the pulse
    clr();
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("sim_dir0", dir, 0);
    run_until(P_WAIT, -1, 1'b1, 1'b1, 1'b0, 10, "sim_open");
    repeat (2) cycle(1'b0, 1'b1, 1'b1, 1'b1);
    run_until(P_IDLE, -1, 1'b1, 1'b1, 1'b0, 12, "sim_close");
    chk("sim_ack_in", ack_in, 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("sim_hold", busy, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("sim_reopen", busy, 1);
    chk("sim_dir1", dir, 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // Safety reversal at pos 2
    clr();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_until(P_WAIT, -1, 1'b0, 1'b0, 1'b0, 10, "rev_open");
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    run_until(P_DOWN, 2, 1'b0, 1'b0, 1'b0, 12, "rev_close");
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rev_up", motor_up, 1);
    chk("rev_pos", pos, 2);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rev_pos_top", pos, 4);
    chk("rev_open", barrier_open, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (8) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rev_acks", n_ai, 1);
    chk("rev_aborts", n_ab, 0);

    // Reset mid-travel at pos 3
    clr();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_until(P_UP, 3, 1'b1, 1'b0, 1'b0, 6, "mid_travel");
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("mid_rst_pos", pos, 0);
    chk("mid_rst_motor", int'(motor_up | motor_down), 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pulses", n_ai + n_ao + n_ab, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("mid_accept", motor_up, 1);

    // Randomized traffic
    rr_in = 1'b0; rr_out = 1'b0; rcar = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rrst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) rr_in = ~rr_in;
      if ($urandom_range(0, 5) == 0) rr_out = ~rr_out;
      if ((m_ai + m_ao + m_ab) != 0 && $urandom_range(0, 1) == 0) begin
        rr_in = 1'b0; rr_out = 1'b0;
      end
      if (rcar) rcar = ($urandom_range(0, 2) != 0);
      else rcar = ($urandom_range(0, 9) == 0);
      cycle(rrst, rr_in, rr_out, rcar);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/gate_actuator.md
GATE_ACTUATOR -- requirements
Module: gate_actuator

Interface
- REQ-001 Parameter T_MOVE, default 4: clk_2 cycles for full barrier travel, closed to open or open to closed.
- REQ-002 Parameter T_WAIT, default 8: clk_2 cycles the open barrier waits for a car before auto-closing.
- REQ-003 Ports (name, direction, width, meaning):
  - clk_2  input  1: system clock; all state updates on posedge.
  - reset  input  1: synchronous, active-high; clock clk_2.
  - req_in  input  1: entry open request; level; held by controller until ack_in/abort.
  - req_out  input  1: exit open request; level; held by controller until ack_out/abort.
  - car_present  input  1: lane sensor; high while a car is under the barrier.
  - motor_up  output  1: drive barrier upward.
  - motor_down  output  1: drive barrier downward.
  - barrier_open  output  1: barrier fully raised (pos == T_MOVE).
  - busy  output  1: FSM not in IDLE.
  - dir  output  1: direction latched at request accept; 0 = entry, 1 = exit.
  - ack_in  output  1: one-cycle pulse; entry car passed and barrier closed.
  - ack_out  output  1: one-cycle pulse; exit car passed and barrier closed.
  - abort  output  1: one-cycle pulse; request ended by timeout, no car passed.
  - pos  output  $clog2(T_MOVE+1): barrier position; 0 = closed, T_MOVE = open.

Function
- REQ-004 The FSM SHALL have states IDLE, OPENING, WAIT_CAR, PASSING, CLOSING.
- REQ-005 IDLE: on req_in, go to OPENING with dir=0. Else on req_out, go to OPENING with dir=1. If both are high in the same cycle, entry wins.
- REQ-006 OPENING: motor_up=1 and pos increments once per cycle. When pos reaches T_MOVE, the next state SHALL be WAIT_CAR and the wait timer SHALL clear to 0.
- REQ-007 WAIT_CAR: motor off, barrier_open=1, timer increments each cycle.
  - car_present=1: go to PASSING.
  - timer == T_WAIT-1 with no car: go to CLOSING and mark the request as aborted.
- REQ-008 PASSING: motor off. Stay while car_present=1. On car_present=0, go to CLOSING and mark the request as passed.
- REQ-009 CLOSING: motor_down=1 and pos decrements once per cycle.
  - When pos reaches 0, go to IDLE and pulse exactly one output in that same transition cycle:
    - passed with dir=0: ack_in.
    - passed with dir=1: ack_out.
    - aborted: abort.
- REQ-010 Safety reversal: car_present=1 during CLOSING SHALL send the FSM to OPENING on the next cycle, keeping the current pos (no jump).
  - A reversal from an aborted closing SHALL clear the aborted mark.
  - After reopening, the FSM SHALL return to WAIT_CAR.
- REQ-011 motor_up and motor_down SHALL never be high in the same cycle.
- REQ-012 pos SHALL saturate: it never exceeds T_MOVE and never goes below 0.
- REQ-013 Request inputs SHALL be ignored outside IDLE. A request still high at the return to IDLE SHALL be accepted no earlier than the cycle after the ack/abort pulse.
- REQ-014 ack_in, ack_out and abort SHALL be mutually exclusive and at most one cycle wide.
- REQ-015 dir SHALL hold its value from accept until the next accept.

Reset
- REQ-016 Reset SHALL take priority over all other inputs, including mid-operation.
- REQ-017 Reset values: IDLE, pos=0, timer=0, dir=0, all outputs low.
- REQ-018 Reset SHALL NOT generate ack_in, ack_out or abort, even if asserted during CLOSING.
- REQ-019 The first request SHALL be accepted in the first cycle after reset deasserts.

Verification
- REQ-020 Entry pass, T_MOVE=4, T_WAIT=8: req_in=1 -> motor_up for 4 cycles, pos 1..4, barrier_open. car_present high 3 cycles then low -> motor_down for 4 cycles, pos 3..0, one ack_in pulse, busy=0.
- REQ-021 Timeout: req_out=1, no car -> open after 4 cycles, WAIT_CAR for 8 cycles, close in 4 cycles, one abort pulse, no ack_out, dir=1.
- REQ-022 Simultaneous requests: req_in=req_out=1 in IDLE -> dir=0. After ack_in, with req_out still high -> second cycle opens with dir=1.
- REQ-023 Safety reversal: car_present=1 at pos=2 while CLOSING -> next cycle OPENING from pos=2, reaches 4 in 2 cycles, WAIT_CAR. Then car passes -> single ack.
- REQ-024 Reset mid-travel: reset asserted at pos=3 in OPENING -> next cycle pos=0, IDLE, motors low, no pulse outputs. Held req_in is accepted the cycle after reset drops.
- REQ-025 Every test SHALL assert continuously: motor_up and motor_down are never both high, pos ≤ T_MOVE, and at most one pulse output is high per cycle.
